// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types, defaults and width helper for the serial pattern detector
package seq_det_pkg;

  localparam int N_DEFAULT     = 4;
  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  // Width needed to hold a fill level of 0..n inclusive
  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with sticky saturation flag
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
      // Flag rises on the same edge the count lands on its ceiling
      if (count == CNT_MAX - CNT_W'(1)) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - programmable N-bit serial pattern detector with masking and hit counter
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x_valid,
  input  logic             x,
  input  logic             cfg_we,
  input  logic [N-1:0]     cfg_pattern,
  input  logic [N-1:0]     cfg_mask,
  input  logic             overlap,
  output logic             y,
  output logic [CNT_W-1:0] hit_count,
  output logic             hit_sat
);

  localparam int FILL_W = fill_w(N);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);

  state_e            state;
  logic [FILL_W-1:0] fill;
  logic [N-1:0]      win;
  logic [N-1:0]      pattern;
  logic [N-1:0]      mask;

  logic [N-1:0]      win_next;
  logic [FILL_W-1:0] fill_next;
  logic              full_next;
  logic              match;
  logic              hit_inc;

  always_comb begin
    win_next  = {win[N-2:0], x};
    fill_next = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    // Window is complete after this bit if already armed or this is the Nth bit
    full_next = (state == ST_ARMED) || (fill == FILL_LAST);
    match     = x_valid && full_next && (((win_next ^ pattern) & mask) == '0);
    hit_inc   = match && !cfg_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_FILL;
      fill    <= '0;
      win     <= '0;
      pattern <= '0;
      mask    <= '1;
      y       <= 1'b0;
    end else if (cfg_we) begin
      state   <= ST_FILL;
      fill    <= '0;
      win     <= '0;
      pattern <= cfg_pattern;
      mask    <= cfg_mask;
      y       <= 1'b0;
    end else if (x_valid) begin
      win <= win_next;
      y   <= match;
      if (match && !overlap) begin
        fill  <= '0;
        state <= ST_FILL;
      end else begin
        fill  <= fill_next;
        state <= (fill_next == FILL_FULL) ? ST_ARMED : ST_FILL;
      end
    end else begin
      y <= 1'b0;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_hit_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (hit_inc),
    .count(hit_count),
    .sat  (hit_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param against a bit-history model
module tb_seq_detector_param;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, x_valid, x, cfg_we, overlap;
  logic [N-1:0] cfg_pattern, cfg_mask;

  logic       y8, sat8, y2, sat2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  seq_detector_param #(.N(N), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .overlap(overlap),
    .y(y8), .hit_count(cnt8), .hit_sat(sat8)
  );

  seq_detector_param #(.N(N), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .overlap(overlap),
    .y(y2), .hit_count(cnt2), .hit_sat(sat2)
  );

  typedef struct {
    logic       y;
    logic [7:0] cnt8;
    logic       sat8;
    logic [1:0] cnt2;
    logic       sat2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: history of accepted bits and how many arrived since the last restart
  logic [N-1:0] m_pat, m_mask;
  int           hist[$];
  int           m_since;
  int           m_cnt8, m_cnt2;
  logic         m_y;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic we, input logic [N-1:0] pat,
                            input logic [N-1:0] msk, input logic v, input logic b,
                            input logic ov);
    logic hit;
    if (rst) begin
      m_pat = '0; m_mask = '1; hist.delete(); m_since = 0;
      m_y = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else if (we) begin
      m_pat = pat; m_mask = msk; hist.delete(); m_since = 0; m_y = 1'b0;
    end else if (v) begin
      hist.push_back(int'(b));
      if (hist.size() > N) void'(hist.pop_front());
      if (m_since < N) m_since++;
      hit = (m_since == N);
      if (hit) begin
        // bit i of the pattern pairs with the bit received i bits ago
        for (int i = 0; i < N; i++) begin
          if (m_mask[i] && (hist[hist.size() - 1 - i] != int'(m_pat[i]))) hit = 1'b0;
        end
      end
      m_y = hit;
      if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
        if (!ov) m_since = 0;
      end
    end else begin
      m_y = 1'b0;
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [N-1:0] pat,
                       input logic [N-1:0] msk, input logic v, input logic b,
                       input logic ov);
    exp_t e;
    reset = rst; cfg_we = we; cfg_pattern = pat; cfg_mask = msk;
    x_valid = v; x = b; overlap = ov;
    @(posedge clk);
    model_step(rst, we, pat, msk, v, b, ov);
    e.y = m_y; e.cnt8 = 8'(m_cnt8); e.sat8 = (m_cnt8 == 255);
    e.cnt2 = 2'(m_cnt2); e.sat2 = (m_cnt2 == 3);
    sb.push_back(e);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_cfg(input logic [N-1:0] pat, input logic [N-1:0] msk);
    drive(1'b0, 1'b1, pat, msk, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [15:0] bits, input int len, input logic ov, input int gap);
    logic [15:0] b;
    b = bits;
    for (int i = len - 1; i >= 0; i--) begin
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, b[i], ov);
      for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, ov);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("y_w8", int'(y8), int'(e.y));
      chk("y_w2", int'(y2), int'(e.y));
      chk("hit_count_w8", int'(cnt8), int'(e.cnt8));
      chk("hit_sat_w8", int'(sat8), int'(e.sat8));
      chk("hit_count_w2", int'(cnt2), int'(e.cnt2));
      chk("hit_sat_w2", int'(sat2), int'(e.sat2));
    end
  end

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_mask = '0;
    x_valid = 1'b0; x = 1'b0; overlap = 1'b0;
    m_pat = '0; m_mask = '1; m_since = 0; m_cnt8 = 0; m_cnt2 = 0; m_y = 1'b0;
    do_reset();
    do_reset();

    // overlap: 1011011 gives two hits
    do_cfg(4'b1011, 4'b1111);
    send(16'b1011011, 7, 1'b1, 0);

    // non-overlap: one hit, then 10111011 adds two more
    do_reset();
    do_cfg(4'b1011, 4'b1111);
    send(16'b1011011, 7, 1'b0, 0);
    send(16'b10111011, 8, 1'b0, 0);

    // masking
    do_cfg(4'b1001, 4'b1001);
    send(16'b1101, 4, 1'b1, 0);
    do_cfg(4'b1001, 4'b1001);
    send(16'b0111, 4, 1'b1, 0);

    // gapped input
    do_cfg(4'b1011, 4'b1111);
    send(16'b1011, 4, 1'b1, 2);

    // mid-stream reconfiguration with a simultaneous valid bit
    do_cfg(4'b1011, 4'b1111);
    send(16'b101, 3, 1'b1, 0);
    drive(1'b0, 1'b1, 4'b1011, 4'b1111, 1'b1, 1'b1, 1'b1);
    send(16'b1, 1, 1'b1, 0);
    send(16'b1011, 4, 1'b1, 0);

    // saturation of the narrow counter, then reset restores defaults
    do_reset();
    do_cfg(4'b1011, 4'b1111);
    send(16'b1011011011011, 13, 1'b1, 0);
    drive(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1);
    send(16'b0000, 4, 1'b1, 0);

    // all-zero mask matches every valid bit once armed
    do_cfg(4'b0110, 4'b0000);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 4'h0, 4'h0, 1'($urandom_range(0, 1)), 1'($urandom), 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, w;
      r = ($urandom_range(0, 299) == 0);
      w = ($urandom_range(0, 39) == 0);
      drive(r, w, 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111,
            ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 1) == 1));
    end

    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
